// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Assembles a little-endian byte stream into 32-bit words and writes
//            them into an instruction memory at a bounds-checked word index.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [63:0]   base_addr_i,
    input  logic [AW:0]   word_count_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_byte_i,
    output logic          in_ready_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [31:0]   wr_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic [1:0]    byte_cnt_q,  byte_cnt_d;
    logic [AW-1:0] index_q,     index_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [31:0]   word_q,      word_d;
    logic [AW-1:0] wr_addr_q,   wr_addr_d;
    logic [31:0]   wr_data_q,   wr_data_d;
    logic          err_q,       err_d;

    logic [64:0]   w_end_word;
    logic          w_reject;
    logic [31:0]   w_word_ins;

    // End index is formed in 65 bits so a huge base address cannot wrap past the check.
    assign w_end_word = {3'b000, base_addr_i[63:2]} + {{(64-AW){1'b0}}, word_count_i};
    assign w_reject   = (base_addr_i[1:0] != 2'b00) ||
                        (word_count_i == '0) ||
                        (w_end_word > 65'(DEPTH));

    always_comb begin
        w_word_ins = word_q;
        case (byte_cnt_q)
            2'd0:    w_word_ins[7:0]   = in_byte_i;
            2'd1:    w_word_ins[15:8]  = in_byte_i;
            2'd2:    w_word_ins[23:16] = in_byte_i;
            default: w_word_ins[31:24] = in_byte_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (w_reject) begin
                        err_d = 1'b1;
                    end else begin
                        err_d       = 1'b0;
                        index_d     = base_addr_i[AW+1:2];
                        remaining_d = word_count_i;
                        byte_cnt_d  = 2'd0;
                        state_d     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid_i) begin
                    word_d     = w_word_ins;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Write-port values are captured here so they are stable in WRITE and hold after it.
                    if (byte_cnt_q == 2'd3) begin
                        wr_addr_d = index_q;
                        wr_data_d = w_word_ins;
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                index_d     = index_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == {{AW{1'b0}}, 1'b1}) ? S_DONE : S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            index_q     <= '0;
            remaining_q <= '0;
            word_q      <= 32'd0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o = (state_q == S_LOAD);
    assign wr_en_o    = (state_q == S_WRITE);
    assign done_o     = (state_q == S_DONE);
    assign busy_o     = (state_q != S_IDLE);
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Scoreboard bench for imem_loader; expected writes are queued by the
//            stimulus and consumed by an independent write monitor.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    localparam int C_DEPTH = 1024;
    localparam int C_AW    = 10;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [63:0]     base_addr_i;
    logic [C_AW:0]   word_count_i;
    logic            in_valid_i;
    logic [7:0]      in_byte_i;
    logic            in_ready_o;
    logic            wr_en_o;
    logic [C_AW-1:0] wr_addr_o;
    logic [31:0]     wr_data_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    int checks = 0;
    int errors = 0;
    logic [C_AW+31:0] exp_q[$];

    imem_loader #(.DEPTH(C_DEPTH), .AW(C_AW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .word_count_i (word_count_i),
        .in_valid_i   (in_valid_i),
        .in_byte_i    (in_byte_i),
        .in_ready_o   (in_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_en pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wr_en_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         wr_addr_o, wr_data_o);
            end else begin
                logic [C_AW+31:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr_o), 64'(e[C_AW+31:32]));
                chk("wr_data", 64'(wr_data_o), 64'(e[31:0]));
            end
        end
    end

    task automatic do_start(input logic [63:0] base, input logic [C_AW:0] cnt);
        start_i      = 1'b1;
        base_addr_i  = base;
        word_count_i = cnt;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int   n;
        in_valid_i = 1'b1;
        in_byte_i  = b;
        n = 0;
        forever begin
            @(negedge clk);
            ok = in_ready_o;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: got no in_ready, expected accept of 0x%02h", b);
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int i = 0; i < 4; i++) begin
            if (stall) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (done_o) break;
            n++;
            if (n > 200) break;
        end
        chk(name, 64'(done_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = '0;
        word_count_i = '0;
        in_valid_i   = 1'b0;
        in_byte_i    = 8'h00;

        // Reset state
        @(negedge clk);
        chk("reset_ctrl", 64'({busy_o, in_ready_o, wr_en_o, done_o, err_o}), 64'd0);
        chk("reset_wr", 64'({wr_addr_o, wr_data_o}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word at byte 0x10 -> index 4
        exp_q.push_back({10'd4, 32'h0000_0013});
        do_start(64'h10, 11'd1);
        @(negedge clk);
        chk("load_ready", 64'({busy_o, in_ready_o}), 64'b11);
        @(posedge clk);
        #1;
        send_word(32'h0000_0013, 1'b0);
        @(negedge clk);
        chk("write_cycle", 64'({wr_en_o, in_ready_o, done_o}), 64'b100);
        @(negedge clk);
        chk("done_pulse", 64'({wr_en_o, done_o, busy_o}), 64'b011);
        @(negedge clk);
        chk("back_idle", 64'({done_o, busy_o}), 64'b00);
        chk("wr_hold", 64'({wr_addr_o, wr_data_o}), {22'd0, 10'd4, 32'h0000_0013});
        @(posedge clk);
        #1;

        // Last word of memory is accepted; one past it is rejected
        exp_q.push_back({10'd1023, 32'hDDCC_BBAA});
        do_start(64'hFFC, 11'd1);
        send_word(32'hDDCC_BBAA, 1'b0);
        wait_done("done_top_word");
        do_start(64'hFFC, 11'd2);
        in_valid_i = 1'b1;
        in_byte_i  = 8'h55;
        @(negedge clk);
        chk("oob_reject", 64'({err_o, busy_o, in_ready_o}), 64'b100);
        @(negedge clk);
        chk("oob_stay_idle", 64'({busy_o, in_ready_o, wr_en_o}), 64'b000);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;

        // Zero-length and misaligned starts, then recovery
        do_start(64'h0, 11'd0);
        @(negedge clk);
        chk("zero_count_reject", 64'({err_o, busy_o}), 64'b10);
        @(posedge clk);
        #1;
        do_start(64'h6, 11'd1);
        @(negedge clk);
        chk("misaligned_reject", 64'({err_o, busy_o}), 64'b10);
        @(posedge clk);
        #1;
        exp_q.push_back({10'd8, 32'h0403_0201});
        do_start(64'h20, 11'd1);
        @(negedge clk);
        chk("err_cleared", 64'({err_o, busy_o}), 64'b01);
        @(posedge clk);
        #1;
        send_word(32'h0403_0201, 1'b0);
        wait_done("done_after_err");

        // Three words with random in_valid gaps
        exp_q.push_back({10'd0, 32'h1122_3344});
        exp_q.push_back({10'd1, 32'hA5A5_0F0F});
        exp_q.push_back({10'd2, 32'hDEAD_BEEF});
        do_start(64'h0, 11'd3);
        send_word(32'h1122_3344, 1'b1);
        send_word(32'hA5A5_0F0F, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1);
        wait_done("done_stalled");

        // Reset in the middle of a word
        do_start(64'h40, 11'd1);
        send_byte(8'hEE);
        send_byte(8'hFF);
        rst = 1'b1;
        #1;
        chk("midword_reset", 64'({busy_o, in_ready_o, wr_en_o, err_o}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back({10'd16, 32'h8D7C_6B5A});
        do_start(64'h40, 11'd1);
        send_word(32'h8D7C_6B5A, 1'b0);
        wait_done("done_after_reset");

        // Start pulsed while busy must be ignored
        exp_q.push_back({10'd64, 32'h0000_00B3});
        exp_q.push_back({10'd65, 32'hCAFE_F00D});
        do_start(64'h100, 11'd2);
        send_byte(8'hB3);
        do_start(64'h200, 11'd1);
        @(negedge clk);
        chk("busy_start_ignored", 64'({busy_o, in_ready_o, err_o}), 64'b110);
        @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_word(32'hCAFE_F00D, 1'b1);
        wait_done("done_busy_start");

        repeat (3) @(posedge clk);
        chk("writes_remaining", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, gives the instruction-memory depth in 32-bit words.
REQ-002 Parameter AW, default 10, gives the word-index width (log2 DEPTH).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  64  byte address of the first word; sampled with start.
REQ-007 word_count  input  AW+1  number of words to load (1..DEPTH); sampled with start.
REQ-008 in_valid  input  1  in_byte carries a valid byte.
REQ-009 in_byte  input  8  stream byte; words arrive little-endian.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 wr_en  output  1  write strobe to the instruction memory.
REQ-012 wr_addr  output  AW  word index being written.
REQ-013 wr_data  output  32  word being written.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the last word is written.
REQ-016 err  output  1  sticky flag for a rejected start; cleared by the next accepted start or by rst.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-018 In IDLE with start=1, the start SHALL be rejected when any of these holds: base_addr[1:0]!=0, word_count==0, or base_addr[63:2]+word_count>DEPTH (computed in at least 65 bits with no wrap).
REQ-019 A rejected start SHALL set err=1 and keep the FSM in IDLE.
REQ-020 An accepted start SHALL clear err, load index=base_addr[AW+1:2] and remaining=word_count, clear byte_cnt, and move to LOAD on the next edge.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 In LOAD, in_ready SHALL be 1, and a byte is accepted when in_valid&in_ready.
REQ-023 An accepted byte SHALL be stored in word bits [8*byte_cnt+7 : 8*byte_cnt], and byte_cnt (2 bits) SHALL then increment.
REQ-024 in_valid=0 SHALL stall LOAD with no state change.
REQ-025 On acceptance of the 4th byte (byte_cnt==3), byte_cnt SHALL wrap to 0 and the FSM SHALL move to WRITE.
REQ-026 In WRITE, for exactly one cycle, the block SHALL drive wr_en=1, wr_addr=index, wr_data=assembled word and in_ready=0.
REQ-027 On leaving WRITE, index SHALL increment and remaining SHALL decrement.
REQ-028 After WRITE, the FSM SHALL go to DONE when remaining was 1, else back to LOAD.
REQ-029 The write SHALL occur in the cycle after the 4th byte is accepted, giving a peak throughput of one word per 5 cycles.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-031 in_ready, wr_en and done SHALL be 0 in all states other than those stated above.
REQ-032 Outside WRITE, wr_addr and wr_data SHALL hold their last values.
REQ-033 index SHALL never exceed DEPTH-1 during a write, as guaranteed by REQ-018.
REQ-034 A byte presented in IDLE, WRITE or DONE SHALL NOT be consumed.

Reset
REQ-035 When rst=1, the block SHALL asynchronously force IDLE, byte_cnt=0, index=0, remaining=0, assembled word=0, wr_addr=0, wr_data=0, in_ready=0, wr_en=0, busy=0, done=0 and err=0.
REQ-036 A reset mid-load SHALL discard any partial word and issue no write.
REQ-037 After rst deasserts, the block SHALL be ready for start on the first clk edge.

Verification
REQ-038 Single word: start with base_addr=0x10 and word_count=1, then bytes 13,00,00,00 back-to-back -> one cycle with wr_en=1, wr_addr=4, wr_data=0x00000013, then done pulses one cycle later.
REQ-039 Bounds: base_addr=0xFFC with word_count=1 -> accepted and writes wr_addr=1023; base_addr=0xFFC with word_count=2 -> err=1, busy stays 0, and in_ready stays 0.
REQ-040 Misaligned: base_addr=0x6 -> err=1; a later valid start -> err=0.
REQ-041 Stalls: 3 words with in_valid toggled randomly -> writes at indices 0,1,2 with the correct little-endian data and no extra wr_en pulses.
REQ-042 Reset mid-word: rst asserted after 2 bytes, then a fresh 1-word load -> only the new word is written, with wr_data built from the new bytes only.
REQ-043 Busy start: start pulsed during LOAD with a different base_addr -> ignored, and the original sequence of write addresses is unchanged.
